// File: rtl/core_types_pkg.sv
// core_types_pkg: shared pipeline types, including the stall/flush controller state and control bundle.
package core_types_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } pipe_ctrl_state_t;
  typedef struct packed {
    logic hold_if;
    logic hold_dec;
    logic hold_exe;
    logic hold_mem;
    logic bubble_exe;
    logic bubble_wb;
    logic flush_dec;
  } pipe_ctrl_out_t;
  // Whole pipeline frozen, WB fed a NOP so the stalled MEM result is not retired twice.
  localparam pipe_ctrl_out_t CTRL_FREEZE   = 7'b1111_010;
  localparam pipe_ctrl_out_t CTRL_BRANCH   = 7'b0000_101;
  localparam pipe_ctrl_out_t CTRL_LOAD_USE = 7'b1100_100;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a DEC instruction reading the destination of a load still in EXE.
module load_use_detect (
  input  logic [4:0] dec_addr1,
  input  logic [4:0] dec_addr2,
  input  logic       dec_use1,
  input  logic       dec_use2,
  input  logic [4:0] exe_rd,
  input  logic       exe_Rmem,
  input  logic       exe_Wreg,
  output logic       hazard
);
  assign hazard = exe_Rmem & exe_Wreg & (exe_rd != 5'd0) &
                  ((dec_use1 & (dec_addr1 == exe_rd)) | (dec_use2 & (dec_addr2 == exe_rd)));
endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller: per-stage hold/bubble/flush scheduler with memory-wait FSM and perf counters.
module pipeline_controller
  import core_types_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic [4:0]       dec_addr1,
  input  logic [4:0]       dec_addr2,
  input  logic             dec_use1,
  input  logic             dec_use2,
  input  logic [4:0]       exe_rd,
  input  logic             exe_Rmem,
  input  logic             exe_Wreg,
  input  logic             exe_branch,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             hold_if,
  output logic             hold_dec,
  output logic             hold_exe,
  output logic             hold_mem,
  output logic             bubble_exe,
  output logic             bubble_wb,
  output logic             flush_dec,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       ctrl_state
);
  pipe_ctrl_state_t r_state, w_next;
  pipe_ctrl_out_t   w_ctl;
  logic [15:0]      r_wait, w_wait_next;
  logic [CNT_W-1:0] r_stall, r_flush;
  logic             w_load_use, w_mem_stall;

  load_use_detect u_lud (
    .dec_addr1(dec_addr1),
    .dec_addr2(dec_addr2),
    .dec_use1 (dec_use1),
    .dec_use2 (dec_use2),
    .exe_rd   (exe_rd),
    .exe_Rmem (exe_Rmem),
    .exe_Wreg (exe_Wreg),
    .hazard   (w_load_use)
  );

  assign w_mem_stall = mem_req & ~mem_ready & (r_state != ERROR);
  // A branch squashes the DEC instruction, so it wins over a coincident load-use.
  assign w_ctl = (r_state == ERROR || w_mem_stall) ? CTRL_FREEZE :
                 exe_branch ? CTRL_BRANCH :
                 w_load_use ? CTRL_LOAD_USE : '0;

  always_comb begin
    w_next      = r_state;
    w_wait_next = r_wait;
    case (r_state)
      RUN: if (w_mem_stall) begin
        w_next      = MEM_WAIT;
        w_wait_next = 16'd1;
      end
      MEM_WAIT: if (!w_mem_stall) begin
        w_next      = RUN;
        w_wait_next = '0;
      end else if (r_wait == 16'(MEM_TIMEOUT)) w_next = ERROR;
      else w_wait_next = r_wait + 16'd1;
      default: w_next = ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_state <= RUN;
      r_wait  <= '0;
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_next;
      if (w_ctl.hold_if && r_state != ERROR && !(&r_stall)) r_stall <= r_stall + CNT_W'(1);
      if (w_ctl.flush_dec && !(&r_flush)) r_flush <= r_flush + CNT_W'(1);
    end
  end

  assign {hold_if, hold_dec, hold_exe, hold_mem, bubble_exe, bubble_wb, flush_dec} = nReset ? w_ctl : '0;
  assign mem_timeout_err = (r_state == ERROR);
  assign stall_cycles    = r_stall;
  assign flush_count     = r_flush;
  assign ctrl_state      = r_state;
endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller: scoreboard bench driving a default-parameter and a small-parameter controller in parallel.
module tb_pipeline_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       nrst;
    logic [4:0] a1, a2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       rmem, wreg, br, mreq, mrdy;
  } in_t;

  typedef struct {
    logic [6:0] ctl;
    logic [1:0] st;
    logic       err;
    longint     sc, fc;
  } exp_t;

  in_t x = '0;
  logic [6:0]  ctl_a, ctl_b;
  logic [1:0]  st_a, st_b;
  logic        err_a, err_b;
  logic [31:0] sc_a, fc_a;
  logic [2:0]  sc_b, fc_b;

  pipeline_controller #(.MEM_TIMEOUT(255), .CNT_W(32)) dut_a (
    .clk(clk), .nReset(x.nrst), .dec_addr1(x.a1), .dec_addr2(x.a2), .dec_use1(x.u1), .dec_use2(x.u2),
    .exe_rd(x.rd), .exe_Rmem(x.rmem), .exe_Wreg(x.wreg), .exe_branch(x.br), .mem_req(x.mreq), .mem_ready(x.mrdy),
    .hold_if(ctl_a[6]), .hold_dec(ctl_a[5]), .hold_exe(ctl_a[4]), .hold_mem(ctl_a[3]),
    .bubble_exe(ctl_a[2]), .bubble_wb(ctl_a[1]), .flush_dec(ctl_a[0]),
    .mem_timeout_err(err_a), .stall_cycles(sc_a), .flush_count(fc_a), .ctrl_state(st_a)
  );

  pipeline_controller #(.MEM_TIMEOUT(4), .CNT_W(3)) dut_b (
    .clk(clk), .nReset(x.nrst), .dec_addr1(x.a1), .dec_addr2(x.a2), .dec_use1(x.u1), .dec_use2(x.u2),
    .exe_rd(x.rd), .exe_Rmem(x.rmem), .exe_Wreg(x.wreg), .exe_branch(x.br), .mem_req(x.mreq), .mem_ready(x.mrdy),
    .hold_if(ctl_b[6]), .hold_dec(ctl_b[5]), .hold_exe(ctl_b[4]), .hold_mem(ctl_b[3]),
    .bubble_exe(ctl_b[2]), .bubble_wb(ctl_b[1]), .flush_dec(ctl_b[0]),
    .mem_timeout_err(err_b), .stall_cycles(sc_b), .flush_count(fc_b), .ctrl_state(st_b)
  );

  int     n_chk = 0, n_fail = 0;
  exp_t   q0[$], q1[$];
  exp_t   ea, eb;
  bit     m_err[2]    = '{0, 0};
  int     m_consec[2] = '{0, 0};
  longint m_sc[2]     = '{0, 0};
  longint m_fc[2]     = '{0, 0};
  int     m_t[2]      = '{255, 4};
  longint m_max[2]    = '{64'hFFFF_FFFF, 7};

  task automatic chk(input string n, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, req, $time);
    end
  endtask

  // Reference: state tracked as "consecutive stalled cycles" plus an error latch.
  task automatic step(input int k, input in_t v, output exp_t e);
    bit lu, stalled;
    lu = v.rmem && v.wreg && v.rd != 0 && ((v.u1 && v.a1 == v.rd) || (v.u2 && v.a2 == v.rd));
    stalled = v.mreq && !v.mrdy;
    e.st  = m_err[k] ? 2'd2 : (m_consec[k] > 0 ? 2'd1 : 2'd0);
    e.err = m_err[k];
    e.sc  = m_sc[k];
    e.fc  = m_fc[k];
    if (!v.nrst) e.ctl = 7'b0;
    else if (m_err[k] || stalled) e.ctl = 7'b1111010;
    else if (v.br) e.ctl = 7'b0000101;
    else if (lu) e.ctl = 7'b1100100;
    else e.ctl = 7'b0;
    if (!v.nrst) begin
      m_err[k] = 0; m_consec[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end else begin
      if (e.ctl[6] && !m_err[k] && m_sc[k] < m_max[k]) m_sc[k]++;
      if (e.ctl[0] && m_fc[k] < m_max[k]) m_fc[k]++;
      if (!m_err[k]) begin
        if (stalled) begin
          m_consec[k]++;
          if (m_consec[k] == m_t[k] + 1) m_err[k] = 1;
        end else m_consec[k] = 0;
      end
    end
  endtask

  task automatic apply(input in_t v);
    exp_t e;
    @(posedge clk);
    #1;
    x = v;
    step(0, v, e); q0.push_back(e);
    step(1, v, e); q1.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) begin
      ea = q0.pop_front();
      chk("a_ctl", ctl_a, ea.ctl); chk("a_state", st_a, ea.st); chk("a_err", err_a, ea.err);
      chk("a_stall_cycles", sc_a, ea.sc); chk("a_flush_count", fc_a, ea.fc);
    end
    if (q1.size() > 0) begin
      eb = q1.pop_front();
      chk("b_ctl", ctl_b, eb.ctl); chk("b_state", st_b, eb.st); chk("b_err", err_b, eb.err);
      chk("b_stall_cycles", sc_b, eb.sc); chk("b_flush_count", fc_b, eb.fc);
    end
  end

  initial begin
    in_t idle, rst, v, lu;
    idle = '0; idle.nrst = 1'b1;
    rst = '0;
    lu = idle; lu.rmem = 1; lu.wreg = 1; lu.rd = 5'd5; lu.a1 = 5'd5; lu.u1 = 1;
    repeat (2) apply(rst);
    apply(lu); apply(idle);
    v = lu; v.rd = 0; v.a1 = 0; apply(v);
    v = idle; v.rmem = 1; v.wreg = 1; v.rd = 5'd7; v.a2 = 5'd7; v.u2 = 0; v.a1 = 5'd3; v.u1 = 1; apply(v);
    v = lu; v.br = 1; apply(v); apply(idle);
    v = idle; v.mreq = 1; apply(v); v.br = 1; apply(v); apply(v);
    v.mrdy = 1; apply(v); apply(idle);
    v = idle; v.mreq = 1; repeat (7) apply(v);
    v.mrdy = 1; repeat (2) apply(v);
    apply(rst); apply(idle);
    repeat (9) apply(lu);
    apply(idle);
    v = idle; v.mreq = 1; repeat (258) apply(v);
    v.mrdy = 1; repeat (2) apply(v);
    apply(rst); apply(idle);
    repeat (600) begin
      v.nrst = ($urandom_range(0, 49) != 0);
      v.a1 = 5'($urandom_range(0, 3)); v.a2 = 5'($urandom_range(0, 3)); v.rd = 5'($urandom_range(0, 3));
      v.u1 = 1'($urandom); v.u2 = 1'($urandom); v.rmem = 1'($urandom); v.wreg = 1'($urandom);
      v.br = ($urandom_range(0, 5) == 0); v.mreq = 1'($urandom); v.mrdy = ($urandom_range(0, 3) != 0);
      apply(v);
    end
    repeat (2) apply(idle);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", q0.size() + q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
